// File: rtl/main_fsm_if.sv
// ---------------------------------------------------------------------------
// main_fsm_if
// Bundles the signals exchanged between the multicycle main controller and
// the datapath it drives.
//   op          [6:0]  opcode from the instruction register  (datapath -> fsm)
//   zero               ALU zero flag                          (datapath -> fsm)
//   pc_write           PC register enable                     (fsm -> datapath)
//   adr_src            memory address select                  (fsm -> datapath)
//   mem_write          data memory write enable               (fsm -> datapath)
//   ir_write           instruction/old-PC register enable     (fsm -> datapath)
//   result_src  [1:0]  result mux select                      (fsm -> datapath)
//   alu_src_a   [1:0]  ALU A select                           (fsm -> datapath)
//   alu_src_b   [1:0]  ALU B select                           (fsm -> datapath)
//   imm_src     [1:0]  immediate format                       (fsm -> datapath)
//   reg_write          register file write enable             (fsm -> datapath)
//   alu_op      [1:0]  ALU decoder control                    (fsm -> datapath)
//   instr_done         last cycle of an instruction           (fsm -> datapath)
//   illegal            unsupported opcode seen in DECODE      (fsm -> datapath)
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface main_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_op,
               instr_done, illegal
    );

    modport slave (
        output op, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_op,
               instr_done, illegal
    );
endinterface

// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm
// Moore main controller of the multicycle RV32I-subset core. Steps each
// instruction through FETCH/DECODE/execute/memory/writeback states and
// drives the datapath enables, mux selects and the 2-bit ALU decoder op.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    main_fsm_if.master (op, zero in; all control signals out)
// Configuration macro:
//   MAIN_FSM_JAL_EN  when defined, the JAL state exists and opcode 1101111
//                    executes as DECODE -> JAL -> ALUWB; otherwise that
//                    opcode is reported as illegal.
// ---------------------------------------------------------------------------
module main_fsm (
    input  logic       clk,
    input  logic       rst_n,
    main_fsm_if.master bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
`ifdef MAIN_FSM_JAL_EN
        S_JAL      = 4'd9,
`endif
        S_BEQ      = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic [1:0] imm_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MAIN_FSM_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                state_d    = S_FETCH;
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                state_d    = S_FETCH;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECR: begin
                state_d   = S_ALUWB;
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                state_d   = S_ALUWB;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                state_d    = S_FETCH;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MAIN_FSM_JAL_EN
            S_JAL: begin
                state_d   = S_ALUWB;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
`endif
            S_BEQ: begin
                state_d    = S_FETCH;
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            // Unreachable encodings recover to FETCH with all outputs idle.
            default: state_d = S_FETCH;
        endcase

        // While reset is held, present FETCH selects but keep every enable
        // and status flag low, so a reset landing in MEMWRITE/ALUWB cannot
        // commit a write.
        if (!rst_n) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            result_src = 2'b10;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            reg_write  = 1'b0;
            alu_op     = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write   = pc_update | (branch & bus.zero);
    assign bus.adr_src    = adr_src;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.imm_src    = imm_src;
    assign bus.reg_write  = reg_write;
    assign bus.alu_op     = alu_op;
    assign bus.instr_done = instr_done;
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk;
    logic rst_n;

    main_fsm_if bus ();

    main_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] exp_q [$];
    string       name_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, imm_src, reg_write, alu_op, instr_done, illegal}
    function automatic logic [16:0] expect_vec(input int st, input logic [6:0] o,
                                               input logic z, input logic rn);
        logic pcu, br, adr, mw, irw, rw, done, ill, legal;
        logic [1:0] rs, a, b, imm, aop;
        pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        legal = (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
                (o == OP_BEQ);
`ifdef MAIN_FSM_JAL_EN
        legal = legal || (o == OP_JAL);
`endif
        case (st)
            0:  begin irw = 1; b = 2'b10; rs = 2'b10; pcu = 1; end
            1:  begin a = 2'b01; b = 2'b01; ill = !legal; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; done = 1; end
            5:  begin adr = 1; mw = 1; done = 1; end
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  begin rw = 1; done = 1; end
            8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            9:  begin a = 2'b01; b = 2'b10; pcu = 1; end
            10: begin a = 2'b10; aop = 2'b01; br = 1; done = 1; end
            default: ;
        endcase
        if (!rn) begin
            pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
            rs = 2'b10; a = 2'b00; b = 2'b10; aop = 2'b00;
        end
        if (o == OP_SW)       imm = 2'b01;
        else if (o == OP_BEQ) imm = 2'b10;
        else if (o == OP_JAL) imm = 2'b11;
        else                  imm = 2'b00;
        return {pcu | (br & z), adr, mw, irw, rs, a, b, imm, rw, aop, done, ill};
    endfunction

    // One clock cycle: drive inputs, queue the outputs required while the
    // DUT sits in state st, then advance to just after the next rising edge.
    task automatic step(input string nm, input logic [6:0] o, input logic z,
                        input logic rn, input int st);
        bus.op   = o;
        bus.zero = z;
        rst_n    = rn;
        exp_q.push_back(expect_vec(st, o, z, rn));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input string nm, input logic [6:0] o, input logic z,
                         input int n, input int s0, input int s1, input int s2,
                         input int s3, input int s4);
        int st [5];
        st = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < n; i++)
            step($sformatf("%s c%0d", nm, i), o, z, 1'b1, st[i]);
    endtask

    logic [16:0] act;
    always_comb
        act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
               bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
               bus.reg_write, bus.alu_op, bus.instr_done, bus.illegal};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %05h required %05h", nm, act, e);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.op   = OP_LW;
        bus.zero = 1'b0;
        @(posedge clk);
        #1;
        step("reset c0", OP_LW, 1'b0, 1'b0, 0);
        step("reset c1", OP_LW, 1'b1, 1'b0, 0);

        instr("lw",       OP_LW,  1'b0, 5, 0, 1, 2, 3, 4);
        instr("sw",       OP_SW,  1'b1, 4, 0, 1, 2, 5, 0);
        instr("rtype",    OP_R,   1'b0, 4, 0, 1, 6, 7, 0);
        instr("itype",    OP_I,   1'b1, 4, 0, 1, 8, 7, 0);
        instr("beq z1",   OP_BEQ, 1'b1, 3, 0, 1, 10, 0, 0);
        instr("beq z0",   OP_BEQ, 1'b0, 3, 0, 1, 10, 0, 0);
        instr("illegal",  OP_BAD, 1'b0, 2, 0, 1, 0, 0, 0);
`ifdef MAIN_FSM_JAL_EN
        instr("jal",      OP_JAL, 1'b0, 4, 0, 1, 9, 7, 0);
`else
        instr("jal off",  OP_JAL, 1'b0, 2, 0, 1, 0, 0, 0);
`endif
        // Reset lands in the MEMWRITE cycle of a store.
        instr("sw rst",   OP_SW,  1'b0, 3, 0, 1, 2, 0, 0);
        step("sw rst memwrite", OP_SW, 1'b0, 1'b0, 5);
        instr("after rst", OP_R,  1'b0, 4, 0, 1, 6, 7, 0);
        instr("lw again", OP_LW,  1'b1, 5, 0, 1, 2, 3, 4);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
